// File: rtl/delta_event_queue.sv
// Timestamped delta-spike event queue: tags each spike with a free-running timestamp,
// buffers it in a first-word-fall-through FIFO and drops (and counts) events on overflow.
module delta_event_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int TS_W   = 8,
    parameter int DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spike_in,
    input  logic [DATA_W-1:0]          delta_in,
    input  logic                       ev_ready,
    output logic                       ev_valid,
    output logic [TS_W+DATA_W-1:0]     ev_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       fifo_full,
    output logic [DROP_W-1:0]          drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int EV_W  = TS_W + DATA_W;

    logic [TS_W-1:0]  ts;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [EV_W-1:0]  mem [DEPTH];
    logic             push;
    logic             pop;
    logic             drop;

    assign fifo_full = (level == LVL_W'(DEPTH));
    assign ev_valid  = (level != '0);
    assign pop       = ev_valid && ev_ready;
    assign push      = spike_in && (!fifo_full || pop);
    assign drop      = spike_in && fifo_full && !pop;

    // Head is read straight from registered storage, so there is no path from spike_in to ev_data.
    assign ev_data   = ev_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ts, delta_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts       <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_delta_event_queue.sv
// Scoreboard bench for delta_event_queue: a cycle-level queue model predicts accepted events,
// level and drops; a negedge monitor checks outputs and pops expected events on each handshake.
module tb_delta_event_queue;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spike_in = 1'b0;
    logic [7:0]  delta_in = 8'd0;
    logic        ev_ready = 1'b0;
    logic        ev_valid;
    logic [15:0] ev_data;
    logic [3:0]  level;
    logic        fifo_full;
    logic [7:0]  drop_cnt;

    delta_event_queue #(.DEPTH(8), .DATA_W(8), .TS_W(8), .DROP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .delta_in(delta_in),
        .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_data(ev_data),
        .level(level), .fifo_full(fifo_full), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          m_level = 0;
    int          m_drop = 0;
    logic [7:0]  m_ts = 8'd0;
    int          cur_level = 0;
    int          cur_drop = 0;
    bit          chk_en = 1'b0;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_data = 16'd0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Model of what the queue should hold: plain list of {timestamp, delta} plus occupancy.
    task automatic cyc(bit sp, logic [7:0] d, bit rd, bit rn);
        bit do_pop;
        bit do_push;
        @(posedge clk);
        #1;
        spike_in  = sp;
        delta_in  = d;
        ev_ready  = rd;
        rst_n     = rn;
        cur_level = m_level;
        cur_drop  = m_drop;
        if (!rn) begin
            m_level = 0;
            m_drop  = 0;
            m_ts    = 8'd0;
            exp_q.delete();
        end else begin
            do_pop  = (m_level > 0) && rd;
            do_push = sp && ((m_level < DEPTH) || do_pop);
            if (do_push) exp_q.push_back({m_ts, d});
            if (sp && !do_push && m_drop < 255) m_drop++;
            m_level = m_level + int'(do_push) - int'(do_pop);
            m_ts    = m_ts + 8'd1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("level", 32'(level), 32'(cur_level));
            check("fifo_full", 32'(fifo_full), 32'(cur_level == DEPTH));
            check("drop_cnt", 32'(drop_cnt), 32'(cur_drop));
            check("ev_valid", 32'(ev_valid), 32'(cur_level != 0));
            if (!ev_valid) check("idle_data", 32'(ev_data), 32'd0);
            if (prev_hold && ev_valid) check("hold_data", 32'(ev_data), 32'(prev_data));
            if (rst_n && ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event actual=%0h required=none at %0t", ev_data, $time);
                end else begin
                    check("event", 32'(ev_data), 32'(exp_q.pop_front()));
                end
            end
            prev_hold = rst_n && ev_valid && !ev_ready;
            prev_data = ev_data;
        end
    end

    task automatic drain();
        repeat (DEPTH + 4) cyc(1'b0, 8'd0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles with spikes present
        cyc(1'b1, 8'd99, 1'b1, 1'b0);
        cyc(1'b1, 8'd98, 1'b1, 1'b0);
        chk_en = 1'b1;

        // Single event at ts=3
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        cyc(1'b1, 8'd12, 1'b1, 1'b1);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        check("tc2_valid", 32'(ev_valid), 32'd1);
        check("tc2_data", 32'(ev_data), 32'h030C);
        drain();

        // Fill and overflow
        for (int i = 1; i <= 10; i++) cyc(1'b1, 8'(i), 1'b0, 1'b1);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check("tc3_level", 32'(level), 32'd8);
        check("tc3_full", 32'(fifo_full), 32'd1);
        check("tc3_drop", 32'(drop_cnt), 32'd2);
        // Full push+pop keeps level at DEPTH
        cyc(1'b1, 8'd50, 1'b1, 1'b1);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check("tc4_level", 32'(level), 32'd8);
        check("tc4_drop", 32'(drop_cnt), 32'd2);
        drain();

        // Timestamp wrap 255 -> 0
        while (m_ts != 8'd255) cyc(1'b0, 8'd0, 1'b1, 1'b1);
        cyc(1'b1, 8'd77, 1'b1, 1'b1);
        cyc(1'b1, 8'd78, 1'b0, 1'b1);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check("tc5_ts255", 32'(ev_data), 32'hFF4D);
        drain();

        // Drop counter saturation
        for (int i = 0; i < DEPTH + 300; i++) cyc(1'b1, 8'(i), 1'b0, 1'b1);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check("tc5_drop_sat", 32'(drop_cnt), 32'd255);
        drain();

        // Reset mid-burst
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i + 20), 1'b0, 1'b1);
        cyc(1'b1, 8'd33, 1'b1, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        check("tc6_level", 32'(level), 32'd0);
        check("tc6_valid", 32'(ev_valid), 32'd0);
        drain();

        // Randomised traffic with varying spike/ready density and rare resets
        for (int blk = 0; blk < 8; blk++) begin
            int sp_pct;
            int rd_pct;
            sp_pct = int'($urandom_range(20, 95));
            rd_pct = int'($urandom_range(10, 95));
            for (int i = 0; i < 200; i++) begin
                cyc(($urandom_range(0, 99) < sp_pct), 8'($urandom),
                    ($urandom_range(0, 99) < rd_pct), ($urandom_range(0, 249) != 0));
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
